// File: rtl/axi_rd_arb.sv
// N-master to 1-slave AXI read arbiter: round-robin grant, one burst in flight,
// master index prepended to ARID, R beat count checked against ARLEN.
module axi_rd_arb #(
    parameter int NUM_MST = 2,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int USER_W  = 1,
    localparam int IDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MST*ID_W-1:0]   m_arid,
    input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MST*LEN_W-1:0]  m_arlen,
    input  logic [NUM_MST*3-1:0]      m_arsize,
    input  logic [NUM_MST*2-1:0]      m_arburst,
    input  logic [NUM_MST*USER_W-1:0] m_aruser,
    input  logic [NUM_MST-1:0]        m_arvalid,
    output logic [NUM_MST-1:0]        m_arready,
    output logic [ID_W-1:0]           m_rid,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [1:0]                m_rresp,
    output logic                      m_rlast,
    output logic [USER_W-1:0]         m_ruser,
    output logic [NUM_MST-1:0]        m_rvalid,
    input  logic [NUM_MST-1:0]        m_rready,
    output logic [IDX_W+ID_W-1:0]     s_arid,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic [LEN_W-1:0]          s_arlen,
    output logic [2:0]                s_arsize,
    output logic [1:0]                s_arburst,
    output logic [USER_W-1:0]         s_aruser,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    input  logic [IDX_W+ID_W-1:0]     s_rid,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic [USER_W-1:0]         s_ruser,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    output logic                      busy,
    output logic                      len_err,
    output logic [1:0]                dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high;
    // valid never waits on ready, and the granted master must hold ARVALID until accepted.
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               len_err_q, len_err_d;
    logic [IDX_W-1:0]   winner;
    logic               found;
    int                 idx;
    logic               unused_rid_idx;

    // First requester at or above rr_ptr, wrapping modulo NUM_MST.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_MST; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_MST;
            if (!found && m_arvalid[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign s_arid    = {grant_q, m_arid[grant_q*ID_W +: ID_W]};
    assign s_araddr  = m_araddr[grant_q*ADDR_W +: ADDR_W];
    assign s_arlen   = m_arlen[grant_q*LEN_W +: LEN_W];
    assign s_arsize  = m_arsize[grant_q*3 +: 3];
    assign s_arburst = m_arburst[grant_q*2 +: 2];
    assign s_aruser  = m_aruser[grant_q*USER_W +: USER_W];

    assign m_rid   = s_rid[ID_W-1:0];
    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;
    assign m_ruser = s_ruser;
    assign unused_rid_idx = ^s_rid[IDX_W+ID_W-1:ID_W];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = 1'b0;
        m_arready  = '0;
        m_rvalid   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_arvalid) begin
                    grant_d = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
                if (m_arvalid[grant_q] && s_arready) begin
                    beat_cnt_d = s_arlen;
                    state_d    = DATA;
                end
            end
            DATA: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
                if (s_rvalid && m_rready[grant_q]) begin
                    if (s_rlast) begin
                        // An early last still ends the burst; it is only flagged.
                        len_err_d = (beat_cnt_q != '0);
                        state_d   = IDLE;
                        rr_ptr_d  = (grant_q == IDX_W'(NUM_MST - 1)) ? '0 : grant_q + 1'b1;
                    end else begin
                        len_err_d = (beat_cnt_q == '0);
                        if (beat_cnt_q != '0) begin
                            beat_cnt_d = beat_cnt_q - 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign len_err   = len_err_q;
    assign dbg_state = state_q;

endmodule
